name_reader: RTL and testbench
==============================

Name: name_reader

Overview:
- Inverse of the product-name lookup: consumes a stream of 7-bit ASCII characters, one per handshake, from the terminal's keypad/UART front end.
- Buffers up to 9 characters. On a terminator it searches the product-name table sequentially and returns the matching 4-bit ProductID with a match flag.
- Sits between the character input path and the sale-transaction logic.

Parameters:
- MAX_LEN, 9, buffer depth in characters; fixed by the 63-bit name format, not to be overridden.
- NUM_PRODUCTS, 12, number of table entries searched (IDs 0..11).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- char_valid  in  1  input character strobe
- char_data  in  7  ASCII character
- char_ready  out  1  block can accept a character
- id_valid  out  1  result available
- id_ready  in  1  downstream consumes result
- ProductID  out  4  matched ID; 4'hF when no match
- match  out  1  1 = name found in table
- overflow  out  1  result flag: more than MAX_LEN characters were entered
- bad_char  out  1  result flag: an illegal character was entered

Behaviour:
- Reset (async, rst_n=0):
  - state=COLLECT, len=0, buffer all 7'h00.
  - char_ready=1, id_valid=0, ProductID=4'hF, match=0, overflow=0, bad_char=0.
- Table (ID: name, packed MSB-first, unused slots 7'h00):
  - 0 BANANA, 1 POTATO, 2 TOMATO, 3 PEACH
  - 4 APPLE, 5 PINEAPPLE, 6 AVOCADO, 7 CHERRY
  - 8 FIG, 9 GRAPE, 10 KIWI, 11 LEMON
- States: COLLECT -> SEARCH -> RESULT -> COLLECT.
- COLLECT:
  - char_ready=1; a character is accepted on each edge where char_valid && char_ready.
  - 0x41-0x5A: stored at position len; len increments.
  - 0x61-0x7A: folded to uppercase (bit 5 cleared), then stored as for 0x41-0x5A.
  - If len==MAX_LEN when a letter arrives: the letter is dropped and the sticky ovf bit is set.
  - 0x08 (backspace): if len>0, len decrements and that slot is cleared to 0; ignored at len=0; does not clear ovf.
  - 0x1B (escape): len=0, buffer cleared, ovf and bad cleared; remains in COLLECT.
  - 0x0D (enter): transitions to SEARCH with idx=0.
  - Any other code: not stored; sticky bad bit is set.
- SEARCH:
  - char_ready=0; one table entry compared per cycle, idx 0..11.
  - Compare is the full 63-bit buffer (zero-padded) against the entry.
  - No early exit: exactly NUM_PRODUCTS cycles, then RESULT.
  - A hit latches ProductID=idx. Names are unique, so at most one hit.
- Match rules:
  - Forced no-match if len==0, ovf=1 or bad=1.
  - Prefixes or extensions of a name do not match (e.g. "PINE" ≠ 5).
- RESULT:
  - id_valid=1; ProductID, match, overflow and bad_char are held stable until id_valid && id_ready.
  - On that handshake: id_valid=0, buffer/len/ovf/bad cleared, state=COLLECT, char_ready=1 in the next cycle.
  - ProductID/match are retained after the handshake until the next RESULT.
- Latency: enter accepted at edge k -> id_valid high after edge k+13 (12 SEARCH cycles plus entry into RESULT).
- id_ready held high: RESULT lasts 1 cycle.
- Characters presented while char_ready=0 are not consumed; the source must hold them.
- Reset asserted mid-SEARCH or mid-RESULT aborts immediately to reset values; no partial result is produced.

Test Plan:
- Send "A","P","P","L","E",0x0D with id_ready=1 -> id_valid pulses at edge k+13; ProductID=4, match=1, overflow=0, bad_char=0.
- Send "k","i","w","i",0x0D -> ProductID=10, match=1 (case folding). Then "P","I","N","E","A","P","P","L","E",0x0D -> ProductID=5.
- Send "F","I","X",0x08,"G",0x0D -> ProductID=8. Separately "FIGS",0x0D -> match=0, ProductID=4'hF.
- Send 10 letters "PINEAPPLES" then 0x0D -> overflow=1, match=0, ProductID=4'hF. Send "AB1",0x1B,"PEACH",0x0D -> ProductID=3, bad_char=0.
- Enter with len=0 -> match=0 after 13 cycles. Hold id_ready=0 for 5 cycles -> outputs stable and char_ready=0; char_valid pulses during this time are not consumed.
- Assert rst_n=0 during SEARCH cycle 6 -> all outputs at reset values; after release, "LEMON",0x0D -> ProductID=11.

Source files
------------

// File: rtl/name_reader_if.sv
// Character-in / product-ID-out handshake bundle for the name reader.
// The reader is the slave; the character source and the result sink together form the master.
interface name_reader_if;
    logic       char_valid;
    logic [6:0] char_data;
    logic       char_ready;
    logic       id_valid;
    logic       id_ready;
    logic [3:0] ProductID;
    logic       match;
    logic       overflow;
    logic       bad_char;

    modport slave (
        input  char_valid, char_data, id_ready,
        output char_ready, id_valid, ProductID, match, overflow, bad_char
    );

    modport master (
        output char_valid, char_data, id_ready,
        input  char_ready, id_valid, ProductID, match, overflow, bad_char
    );
endinterface

// File: rtl/name_reader.sv
// Collects an ASCII product name, then scans the 12-entry name table one entry per cycle
// and reports the matching ProductID together with overflow/illegal-character flags.
module name_reader #(
    parameter int MAX_LEN      = 9,
    parameter int NUM_PRODUCTS = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    name_reader_if.slave  bus
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SEARCH  = 2'd1,
        RESULT  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX  = 4'(NUM_PRODUCTS);
    localparam logic [3:0] MAX_LEN_C = 4'(MAX_LEN);
    localparam logic [3:0] NO_ID     = 4'hF;

    // Names are packed MSB-first, seven bits per character, zero-padded to nine characters.
    function automatic logic [62:0] table_entry(input logic [3:0] id);
        case (id)
            4'd0:    return {7'h42, 7'h41, 7'h4E, 7'h41, 7'h4E, 7'h41, 7'h00, 7'h00, 7'h00};
            4'd1:    return {7'h50, 7'h4F, 7'h54, 7'h41, 7'h54, 7'h4F, 7'h00, 7'h00, 7'h00};
            4'd2:    return {7'h54, 7'h4F, 7'h4D, 7'h41, 7'h54, 7'h4F, 7'h00, 7'h00, 7'h00};
            4'd3:    return {7'h50, 7'h45, 7'h41, 7'h43, 7'h48, 7'h00, 7'h00, 7'h00, 7'h00};
            4'd4:    return {7'h41, 7'h50, 7'h50, 7'h4C, 7'h45, 7'h00, 7'h00, 7'h00, 7'h00};
            4'd5:    return {7'h50, 7'h49, 7'h4E, 7'h45, 7'h41, 7'h50, 7'h50, 7'h4C, 7'h45};
            4'd6:    return {7'h41, 7'h56, 7'h4F, 7'h43, 7'h41, 7'h44, 7'h4F, 7'h00, 7'h00};
            4'd7:    return {7'h43, 7'h48, 7'h45, 7'h52, 7'h52, 7'h59, 7'h00, 7'h00, 7'h00};
            4'd8:    return {7'h46, 7'h49, 7'h47, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
            4'd9:    return {7'h47, 7'h52, 7'h41, 7'h50, 7'h45, 7'h00, 7'h00, 7'h00, 7'h00};
            4'd10:   return {7'h4B, 7'h49, 7'h57, 7'h49, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
            4'd11:   return {7'h4C, 7'h45, 7'h4D, 7'h4F, 7'h4E, 7'h00, 7'h00, 7'h00, 7'h00};
            default: return {63{1'b0}};
        endcase
    endfunction

    state_t     state_r, state_n;
    logic [6:0] name_buf_r [MAX_LEN];
    logic [3:0] len_r;
    logic [3:0] idx_r;
    logic       ovf_r;
    logic       bad_r;
    logic       hit_r;
    logic [3:0] hit_id_r;
    logic       char_ready_r;
    logic       id_valid_r;
    logic [3:0] id_r;
    logic       match_r;
    logic       overflow_r;
    logic       bad_char_r;

    logic [7*MAX_LEN-1:0] name_word_s;
    logic                 accept_s;
    logic                 is_letter_s;
    logic [6:0]           letter_s;
    logic                 forced_miss_s;
    logic                 found_s;

    assign bus.char_ready = char_ready_r;
    assign bus.id_valid   = id_valid_r;
    assign bus.ProductID  = id_r;
    assign bus.match      = match_r;
    assign bus.overflow   = overflow_r;
    assign bus.bad_char   = bad_char_r;

    // Flatten the character buffer into the table's packed name format.
    always_comb begin
        name_word_s = {(7*MAX_LEN){1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            name_word_s[7*(MAX_LEN-i)-1 -: 7] = name_buf_r[i];
        end
    end

    // Character decode; lowercase letters fold to uppercase by clearing bit 5.
    always_comb begin
        accept_s      = bus.char_valid && char_ready_r && (state_r == COLLECT);
        is_letter_s   = ((bus.char_data >= 7'h41) && (bus.char_data <= 7'h5A)) ||
                        ((bus.char_data >= 7'h61) && (bus.char_data <= 7'h7A));
        letter_s      = bus.char_data & 7'h5F;
        forced_miss_s = (len_r == 4'd0) || ovf_r || bad_r;
        found_s       = hit_r && !forced_miss_s;
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            COLLECT: begin
                if (accept_s && (bus.char_data == 7'h0D)) begin
                    state_n = SEARCH;
                end else begin
                    state_n = COLLECT;
                end
            end
            SEARCH: begin
                if (idx_r == LAST_IDX) begin
                    state_n = RESULT;
                end else begin
                    state_n = SEARCH;
                end
            end
            RESULT: begin
                if (bus.id_ready) begin
                    state_n = COLLECT;
                end else begin
                    state_n = RESULT;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    // State register plus handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= COLLECT;
            char_ready_r <= 1'b1;
            id_valid_r   <= 1'b0;
        end else begin
            state_r      <= state_n;
            char_ready_r <= (state_n == COLLECT);
            id_valid_r   <= (state_n == RESULT);
        end
    end

    // Buffer editing, sequential table scan and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                name_buf_r[i] <= 7'h00;
            end
            len_r      <= 4'd0;
            idx_r      <= 4'd0;
            ovf_r      <= 1'b0;
            bad_r      <= 1'b0;
            hit_r      <= 1'b0;
            hit_id_r   <= NO_ID;
            id_r       <= NO_ID;
            match_r    <= 1'b0;
            overflow_r <= 1'b0;
            bad_char_r <= 1'b0;
        end else begin
            case (state_r)
                COLLECT: begin
                    idx_r <= 4'd0;
                    hit_r <= 1'b0;
                    if (accept_s) begin
                        if (is_letter_s) begin
                            if (len_r < MAX_LEN_C) begin
                                name_buf_r[len_r] <= letter_s;
                                len_r             <= len_r + 4'd1;
                            end else begin
                                ovf_r <= 1'b1;
                            end
                        end else if (bus.char_data == 7'h08) begin
                            if (len_r != 4'd0) begin
                                name_buf_r[len_r - 4'd1] <= 7'h00;
                                len_r                    <= len_r - 4'd1;
                            end
                        end else if (bus.char_data == 7'h1B) begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                name_buf_r[i] <= 7'h00;
                            end
                            len_r <= 4'd0;
                            ovf_r <= 1'b0;
                            bad_r <= 1'b0;
                        end else if (bus.char_data != 7'h0D) begin
                            bad_r <= 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    // The extra step at idx==LAST_IDX publishes the result as RESULT is entered.
                    if (idx_r != LAST_IDX) begin
                        if (name_word_s == table_entry(idx_r)) begin
                            hit_r    <= 1'b1;
                            hit_id_r <= idx_r;
                        end
                        idx_r <= idx_r + 4'd1;
                    end else begin
                        match_r    <= found_s;
                        id_r       <= found_s ? hit_id_r : NO_ID;
                        overflow_r <= ovf_r;
                        bad_char_r <= bad_r;
                    end
                end
                RESULT: begin
                    if (bus.id_ready) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            name_buf_r[i] <= 7'h00;
                        end
                        len_r      <= 4'd0;
                        ovf_r      <= 1'b0;
                        bad_r      <= 1'b0;
                        overflow_r <= 1'b0;
                        bad_char_r <= 1'b0;
                    end
                end
                default: begin
                    idx_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_name_reader.sv
// Directed scoreboard bench for name_reader: stimulus pushes expected results, a monitor
// pops and checks them (values, latency, stability) whenever the reader presents a result.
module tb_name_reader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    name_reader_if bus ();

    name_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic        m;
        logic        o;
        logic        b;
        logic [31:0] k;
    } exp_t;

    exp_t sb [$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   last_k = 0;
    bit   in_res = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop one expectation per result, then re-check it every cycle until consumed.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_res = 1'b0;
        end else if (bus.id_valid) begin
            if (!in_res) begin
                in_res = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: id_valid high with empty scoreboard (cycle %0d)", cyc);
                    cur = '{id: 4'hF, m: 1'b0, o: 1'b0, b: 1'b0, k: 32'd0};
                end else begin
                    cur = sb.pop_front();
                    chk("latency", cyc, cur.k + 32'd13);
                end
            end
            chk("ProductID", {28'd0, bus.ProductID}, {28'd0, cur.id});
            chk("match", {31'd0, bus.match}, {31'd0, cur.m});
            chk("overflow", {31'd0, bus.overflow}, {31'd0, cur.o});
            chk("bad_char", {31'd0, bus.bad_char}, {31'd0, cur.b});
            chk("char_ready_in_result", {31'd0, bus.char_ready}, 32'd0);
            if (bus.id_ready) in_res = 1'b0;
        end
    end

    task automatic send_char(input logic [6:0] c);
        int n = 0;
        @(negedge clk);
        bus.char_valid = 1'b1;
        bus.char_data  = c;
        while (!bus.char_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("char_ready_timeout", {31'd0, bus.char_ready}, 32'd1);
        @(posedge clk);
        #1;
        last_k         = cyc;
        bus.char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        byte ch;
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            send_char(ch[6:0]);
        end
    endtask

    task automatic enter(input logic [3:0] id, input logic m, input logic o, input logic b);
        send_char(7'h0D);
        sb.push_back('{id: id, m: m, o: o, b: b, k: 32'(last_k)});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || bus.id_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_char_ready"}, {31'd0, bus.char_ready}, 32'd1);
        chk({tag, "_id_valid"}, {31'd0, bus.id_valid}, 32'd0);
        chk({tag, "_ProductID"}, {28'd0, bus.ProductID}, 32'hF);
        chk({tag, "_match"}, {31'd0, bus.match}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, bus.overflow}, 32'd0);
        chk({tag, "_bad_char"}, {31'd0, bus.bad_char}, 32'd0);
    endtask

    initial begin
        int n;
        int k;
        bus.char_valid = 1'b0;
        bus.char_data  = 7'h00;
        bus.id_ready   = 1'b1;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        send_str("APPLE");      enter(4'd4,  1'b1, 1'b0, 1'b0);
        send_str("kiwi");       enter(4'd10, 1'b1, 1'b0, 1'b0);
        send_str("PINEAPPLE");  enter(4'd5,  1'b1, 1'b0, 1'b0);
        send_str("FIX"); send_char(7'h08); send_str("G");
        enter(4'd8, 1'b1, 1'b0, 1'b0);
        send_str("FIGS");       enter(4'hF,  1'b0, 1'b0, 1'b0);
        send_str("PINEAPPLES"); enter(4'hF,  1'b0, 1'b1, 1'b0);
        send_str("AB1"); send_char(7'h1B); send_str("PEACH");
        enter(4'd3, 1'b1, 1'b0, 1'b0);
        send_char(7'h08); send_str("CHERRY");
        enter(4'd7, 1'b1, 1'b0, 1'b0);
        send_str("PINEAPPLEX"); send_char(7'h08);
        enter(4'hF, 1'b0, 1'b1, 1'b0);
        send_str("Lemon?");     enter(4'hF,  1'b0, 1'b0, 1'b1);
        wait_idle();

        // Empty name with the sink stalled; a held character must not be consumed.
        @(posedge clk);
        #1 bus.id_ready = 1'b0;
        enter(4'hF, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!bus.id_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_id_valid", {31'd0, bus.id_valid}, 32'd1);
        bus.char_valid = 1'b1;
        bus.char_data  = 7'h5A;
        repeat (5) @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        bus.id_ready   = 1'b1;
        send_str("FIG");        enter(4'd8,  1'b1, 1'b0, 1'b0);
        wait_idle();

        // Reset in the middle of the table scan.
        send_str("TOMATO");
        send_char(7'h0D);
        k = last_k;
        n = 0;
        while (cyc < k + 6 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midsearch_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_result_after_reset", {31'd0, bus.id_valid}, 32'd0);
        send_str("LEMON");      enter(4'd11, 1'b1, 1'b0, 1'b0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
